ddr_port_arbiter: RTL and testbench

Two-requester arbiter sharing the single DDR3 Avalon-MM port between the streaming write master and a read-back master. It grants the port round-robin with a bounded hold, forwards the granted master's command, and steers returning read data to the requester that issued each read using an in-order tag FIFO. It sits between the masters and the DDR3 controller port.

---
 rtl/ddr_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_ddr_port_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: shares one DDR3 Avalon-MM port between two masters.
// Round-robin grant with a bounded hold, combinational command forwarding,
// and in-order read-data steering through a small tag FIFO.
module ddr_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_OUTST = 8,
  parameter int HOLD      = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic        [ADDR_W-1:0]           m0_addr,
  input  logic                               m0_write,
  input  logic signed [DATA_W-1:0]           m0_writedata,
  input  logic                               m0_read,
  output logic                               m0_waitrequest,
  output logic signed [DATA_W-1:0]           m0_readdata,
  output logic                               m0_readdatavalid,
  input  logic        [ADDR_W-1:0]           m1_addr,
  input  logic                               m1_write,
  input  logic signed [DATA_W-1:0]           m1_writedata,
  input  logic                               m1_read,
  output logic                               m1_waitrequest,
  output logic signed [DATA_W-1:0]           m1_readdata,
  output logic                               m1_readdatavalid,
  output logic        [ADDR_W-1:0]           ddr_addr,
  output logic                               ddr_write,
  output logic                               ddr_read,
  output logic signed [DATA_W-1:0]           ddr_writedata,
  input  logic                               ddr_waitrequest,
  input  logic signed [DATA_W-1:0]           ddr_readdata,
  input  logic                               ddr_readdatavalid,
  output logic [$clog2(MAX_OUTST+1)-1:0]     outstanding,
  output logic                               err_unexp
);

  localparam int CNT_W  = $clog2(MAX_OUTST + 1);
  localparam int PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int HOLD_W = $clog2(HOLD + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(MAX_OUTST);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_G0, S_G1} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_last;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_tag [MAX_OUTST];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_err_unexp;

  logic w_req0, w_req1, w_full, w_empty;
  logic w_sel_wr, w_sel_rd, w_own_req, w_other_req;
  logic w_accept, w_push, w_pop, w_head, w_yield;
  logic w_enter, w_grant_id;

  assign w_req0  = m0_read | m0_write;
  assign w_req1  = m1_read | m1_write;
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Command mux: forward the granted master, everything zero outside a grant.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    ddr_addr      = '0;
    ddr_writedata = '0;
    w_sel_wr      = 1'b0;
    w_sel_rd      = 1'b0;
    w_own_req     = 1'b0;
    w_other_req   = 1'b0;
    case (r_state)
      S_G0: begin
        ddr_addr      = m0_addr;
        ddr_writedata = m0_writedata;
        w_sel_wr      = m0_write;
        w_sel_rd      = m0_read & ~m0_write;  // read ignored if both asserted
        w_own_req     = w_req0;
        w_other_req   = w_req1;
      end
      S_G1: begin
        ddr_addr      = m1_addr;
        ddr_writedata = m1_writedata;
        w_sel_wr      = m1_write;
        w_sel_rd      = m1_read & ~m1_write;
        w_own_req     = w_req1;
        w_other_req   = w_req0;
      end
      default: ;
    endcase
  end

  assign ddr_write = w_sel_wr;
  assign ddr_read  = w_sel_rd & ~w_full;  // a full tag FIFO stalls reads only
  assign w_accept  = (ddr_write | ddr_read) & ~ddr_waitrequest;

  assign m0_waitrequest = (r_state == S_G0) ? (ddr_waitrequest | (w_sel_rd & w_full)) : 1'b1;
  assign m1_waitrequest = (r_state == S_G1) ? (ddr_waitrequest | (w_sel_rd & w_full)) : 1'b1;

  // Read returns are in order: the FIFO head names the requester.
  assign w_push           = w_accept & ddr_read;
  assign w_pop            = ddr_readdatavalid & ~w_empty;
  assign w_head           = r_tag[r_rd_ptr];
  assign m0_readdatavalid = w_pop & ~w_head;
  assign m1_readdatavalid = w_pop & w_head;
  assign m0_readdata      = ddr_readdata;
  assign m1_readdata      = ddr_readdata;
  assign outstanding      = r_count;
  assign err_unexp        = r_err_unexp;

  // Yield once the hold budget is spent and a rival waits: either on the edge
  // that completes the HOLD-th transfer, or later if no command is stalled on
  // the port (so the controller never sees a pending command withdrawn).
  assign w_yield = w_other_req &
                   (((r_hold_cnt == HOLD_LAST) & w_accept) |
                    ((r_hold_cnt == HOLD_MAX) & ~((ddr_write | ddr_read) & ddr_waitrequest)));

  // Next-state logic: round-robin grant from IDLE, release on drop or yield.
  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    w_grant_id  = r_last;
    case (r_state)
      S_IDLE: begin
        if (w_req0 & w_req1) begin
          w_enter    = 1'b1;
          w_grant_id = ~r_last;
        end else if (w_req0) begin
          w_enter    = 1'b1;
          w_grant_id = 1'b0;
        end else if (w_req1) begin
          w_enter    = 1'b1;
          w_grant_id = 1'b1;
        end
        if (w_enter) w_state_nxt = w_grant_id ? S_G1 : S_G0;
      end
      S_G0, S_G1: begin
        if (!w_own_req || w_yield) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant state, round-robin history and hold counter.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_hold_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_enter) begin
        r_last     <= w_grant_id;
        r_hold_cnt <= '0;
      end else if (w_accept && r_hold_cnt != HOLD_MAX) begin
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      end
    end
  end

  // Tag FIFO storage: written on each accepted read with the granted ID.
  always_ff @(posedge clk) begin
    // NOTE: the tag array has no reset; the pointers and count are reset, so
    // stale entries are never read.
    if (w_push) r_tag[r_wr_ptr] <= (r_state == S_G1);
  end

  // Tag FIFO pointers/count and the sticky unexpected-return flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_err_unexp <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
      if (ddr_readdatavalid && w_empty) r_err_unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed testbench for ddr_port_arbiter with hand-computed expectations.
module tb_ddr_port_arbiter;

  logic               clk = 1'b0;
  logic               rst;
  logic        [15:0] m0_addr, m1_addr, ddr_addr;
  logic               m0_write, m0_read, m1_write, m1_read;
  logic signed [15:0] m0_writedata, m1_writedata, ddr_writedata;
  logic               m0_waitrequest, m1_waitrequest;
  logic signed [15:0] m0_readdata, m1_readdata, ddr_readdata;
  logic               m0_readdatavalid, m1_readdatavalid;
  logic               ddr_write, ddr_read, ddr_waitrequest, ddr_readdatavalid;
  logic        [3:0]  outstanding;
  logic               err_unexp;

  int n_tests = 0;
  int n_fail  = 0;

  ddr_port_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_read(m0_read),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_addr(m1_addr), .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_read(m1_read),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ddr_addr(ddr_addr), .ddr_write(ddr_write), .ddr_read(ddr_read), .ddr_writedata(ddr_writedata),
    .ddr_waitrequest(ddr_waitrequest), .ddr_readdata(ddr_readdata), .ddr_readdatavalid(ddr_readdatavalid),
    .outstanding(outstanding), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are checked at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_addr = '0; m0_write = 0; m0_writedata = '0; m0_read = 0;
    m1_addr = '0; m1_write = 0; m1_writedata = '0; m1_read = 0;
    ddr_waitrequest = 0; ddr_readdata = '0; ddr_readdatavalid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({ddr_write, ddr_read, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, err_unexp} !== 7'b0011000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0011000", {ddr_write, ddr_read, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, err_unexp});
    end
    n_tests++;
    if ({ddr_addr, ddr_writedata} !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus: got %h want 0", {ddr_addr, ddr_writedata});
    end
    n_tests++;
    if (outstanding !== 4'd0) begin
      n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single_writer();
    m0_write = 1; m0_addr = 16'd0; m0_writedata = 16'sh0100;
    @(negedge clk);
    n_tests++;
    if ({ddr_write, m0_waitrequest} !== 2'b01) begin
      n_fail++; $display("FAIL sw_idle: got %b want 01", {ddr_write, m0_waitrequest});
    end
    step();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++;
      if ({ddr_write, ddr_read, m0_waitrequest, m1_waitrequest, ddr_addr, ddr_writedata} !==
          {4'b1001, 16'(i), 16'(16'h0100 + i)}) begin
        n_fail++;
        $display("FAIL sw_write%0d: got ctrl=%b addr=%h data=%h want ctrl=1001 addr=%h data=%h",
                 i, {ddr_write, ddr_read, m0_waitrequest, m1_waitrequest}, ddr_addr, ddr_writedata,
                 16'(i), 16'(16'h0100 + i));
      end
      step();
      m0_addr = 16'(i + 1); m0_writedata = 16'(16'h0100 + i + 1);
    end
    m0_write = 0;
    @(negedge clk);
    n_tests++;
    if ({ddr_write, outstanding} !== 5'b0_0000) begin
      n_fail++; $display("FAIL sw_end: got write=%b outst=%0d want 0/0", ddr_write, outstanding);
    end
    step();
    step();
  endtask

  task automatic test_contention();
    logic [3:0] want;
    do_reset();
    m0_write = 1; m0_addr = 16'h0040; m0_writedata = 16'sh0ABC;
    m1_read  = 1; m1_addr = 16'h0080;
    for (int c = 0; c < 20; c++) begin
      // {ddr_write, ddr_read, m0_waitrequest, m1_waitrequest}
      if (c % 5 == 0)            want = 4'b0011;
      else if ((c / 5) % 2 == 0) want = 4'b1001;
      else                       want = 4'b0110;
      @(negedge clk);
      n_tests++;
      if ({ddr_write, ddr_read, m0_waitrequest, m1_waitrequest} !== want) begin
        n_fail++;
        $display("FAIL contention_c%0d: got %b want %b", c, {ddr_write, ddr_read, m0_waitrequest, m1_waitrequest}, want);
      end
      step();
    end
    m0_write = 0; m1_read = 0;
    @(negedge clk);
    n_tests++;
    if (outstanding !== 4'd8) begin
      n_fail++; $display("FAIL contention_outst: got %0d want 8", outstanding);
    end
    step();
    for (int k = 0; k < 8; k++) begin
      ddr_readdatavalid = 1; ddr_readdata = 16'(k * 16'h0111);
      @(negedge clk);
      n_tests++;
      if ({m0_readdatavalid, m1_readdatavalid, m1_readdata} !== {2'b01, 16'(k * 16'h0111)}) begin
        n_fail++;
        $display("FAIL contention_ret%0d: got v=%b d=%h want v=01 d=%h", k,
                 {m0_readdatavalid, m1_readdatavalid}, m1_readdata, 16'(k * 16'h0111));
      end
      step();
    end
    ddr_readdatavalid = 0;
    @(negedge clk);
    n_tests++;
    if (outstanding !== 4'd0) begin
      n_fail++; $display("FAIL contention_drain: got %0d want 0", outstanding);
    end
    step();
  endtask

  task automatic test_read_steering();
    m1_read = 1; m1_addr = 16'h0010;
    step();
    @(negedge clk);
    n_tests++;
    if ({ddr_read, ddr_addr} !== {1'b1, 16'h0010}) begin
      n_fail++; $display("FAIL steer_m1_cmd: got rd=%b addr=%h want 1/0010", ddr_read, ddr_addr);
    end
    step();
    m1_read = 0; m0_read = 1; m0_addr = 16'h0020;
    step();
    step();
    @(negedge clk);
    n_tests++;
    if ({ddr_read, ddr_addr, m0_waitrequest} !== {1'b1, 16'h0020, 1'b0}) begin
      n_fail++; $display("FAIL steer_m0_cmd: got rd=%b addr=%h wr=%b want 1/0020/0", ddr_read, ddr_addr, m0_waitrequest);
    end
    step();
    m0_read = 0;
    ddr_readdatavalid = 1; ddr_readdata = 16'shAAAA;
    @(negedge clk);
    n_tests++;
    if ({m0_readdatavalid, m1_readdatavalid, m1_readdata} !== {2'b01, 16'hAAAA}) begin
      n_fail++; $display("FAIL steer_first: got v=%b d=%h want v=01 d=aaaa", {m0_readdatavalid, m1_readdatavalid}, m1_readdata);
    end
    step();
    ddr_readdata = 16'shBBBB;
    @(negedge clk);
    n_tests++;
    if ({m0_readdatavalid, m1_readdatavalid, m0_readdata} !== {2'b10, 16'hBBBB}) begin
      n_fail++; $display("FAIL steer_second: got v=%b d=%h want v=10 d=bbbb", {m0_readdatavalid, m1_readdatavalid}, m0_readdata);
    end
    step();
    ddr_readdatavalid = 0;
    @(negedge clk);
    n_tests++;
    if ({outstanding, err_unexp} !== 5'b0000_0) begin
      n_fail++; $display("FAIL steer_end: got outst=%0d err=%b want 0/0", outstanding, err_unexp);
    end
    step();
  endtask

  task automatic test_full();
    m0_read = 1; m0_addr = 16'h0200;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      n_tests++;
      if ({ddr_read, m0_waitrequest} !== ((c == 0) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL full_fill%0d: got %b want %b", c, {ddr_read, m0_waitrequest}, (c == 0) ? 2'b01 : 2'b10);
      end
      step();
    end
    @(negedge clk);
    n_tests++;
    if ({ddr_read, m0_waitrequest, outstanding} !== {2'b01, 4'd8}) begin
      n_fail++; $display("FAIL full_stall: got rd/wr=%b outst=%0d want 01/8", {ddr_read, m0_waitrequest}, outstanding);
    end
    step();
    ddr_readdatavalid = 1; ddr_readdata = 16'sh1357;
    @(negedge clk);
    n_tests++;
    if ({m0_readdatavalid, m1_readdatavalid, m0_waitrequest} !== 3'b101) begin
      n_fail++; $display("FAIL full_pop: got %b want 101", {m0_readdatavalid, m1_readdatavalid, m0_waitrequest});
    end
    step();
    ddr_readdatavalid = 0;
    @(negedge clk);
    n_tests++;
    if ({ddr_read, m0_waitrequest, outstanding} !== {2'b10, 4'd7}) begin
      n_fail++; $display("FAIL full_ninth: got rd/wr=%b outst=%0d want 10/7", {ddr_read, m0_waitrequest}, outstanding);
    end
    step();
    m0_read = 0;
    @(negedge clk);
    n_tests++;
    if (outstanding !== 4'd8) begin
      n_fail++; $display("FAIL full_refill: got %0d want 8", outstanding);
    end
    step();
    ddr_readdatavalid = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_tests++;
      if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10) begin
        n_fail++; $display("FAIL full_drain%0d: got %b want 10", k, {m0_readdatavalid, m1_readdatavalid});
      end
      step();
    end
    ddr_readdatavalid = 0;
    @(negedge clk);
    n_tests++;
    if ({outstanding, err_unexp} !== 5'b0000_0) begin
      n_fail++; $display("FAIL full_end: got outst=%0d err=%b want 0/0", outstanding, err_unexp);
    end
    step();
  endtask

  task automatic test_waitrequest();
    m0_write = 1; m0_addr = 16'h0033; m0_writedata = 16'sh1234;
    ddr_waitrequest = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if ({ddr_write, m0_waitrequest, ddr_addr, ddr_writedata} !== ((c == 0) ? {2'b01, 32'h0} : {2'b11, 32'h0033_1234})) begin
        n_fail++; $display("FAIL wait_stall%0d: got ctrl=%b addr=%h data=%h", c, {ddr_write, m0_waitrequest}, ddr_addr, ddr_writedata);
      end
      step();
    end
    ddr_waitrequest = 0;
    @(negedge clk);
    n_tests++;
    if ({ddr_write, m0_waitrequest} !== 2'b10) begin
      n_fail++; $display("FAIL wait_accept: got %b want 10", {ddr_write, m0_waitrequest});
    end
    step();
    m1_write = 1; m1_addr = 16'h0044; m1_writedata = 16'sh0044;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if ({ddr_write, m0_waitrequest, m1_waitrequest} !== 3'b101) begin
        n_fail++; $display("FAIL wait_hold%0d: got %b want 101", c, {ddr_write, m0_waitrequest, m1_waitrequest});
      end
      step();
    end
    @(negedge clk);
    n_tests++;
    if ({ddr_write, m0_waitrequest, m1_waitrequest} !== 3'b011) begin
      n_fail++; $display("FAIL wait_idle: got %b want 011", {ddr_write, m0_waitrequest, m1_waitrequest});
    end
    step();
    @(negedge clk);
    n_tests++;
    if ({m1_waitrequest, ddr_addr} !== {1'b0, 16'h0044}) begin
      n_fail++; $display("FAIL wait_handover: got wr=%b addr=%h want 0/0044", m1_waitrequest, ddr_addr);
    end
    step();
    m0_write = 0; m1_write = 0;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    m1_read = 1; m1_addr = 16'h0300;
    for (int c = 0; c < 4; c++) step();
    ddr_waitrequest = 1;
    @(negedge clk);
    n_tests++;
    if ({ddr_read, outstanding} !== {1'b1, 4'd3}) begin
      n_fail++; $display("FAIL rmid_pre: got rd=%b outst=%0d want 1/3", ddr_read, outstanding);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({ddr_read, m0_waitrequest, m1_waitrequest, outstanding, ddr_addr} !== {3'b011, 4'd0, 16'h0}) begin
      n_fail++;
      $display("FAIL rmid_async: got rd=%b wr=%b outst=%0d addr=%h want 0/11/0/0000",
               ddr_read, {m0_waitrequest, m1_waitrequest}, outstanding, ddr_addr);
    end
    m1_read = 0; ddr_waitrequest = 0;
    step();
    rst = 1'b0;
    ddr_readdatavalid = 1; ddr_readdata = 16'sh5555;
    @(negedge clk);
    n_tests++;
    if ({m0_readdatavalid, m1_readdatavalid, err_unexp} !== 3'b000) begin
      n_fail++; $display("FAIL rmid_pulse: got %b want 000", {m0_readdatavalid, m1_readdatavalid, err_unexp});
    end
    step();
    ddr_readdatavalid = 0;
    @(negedge clk);
    n_tests++;
    if (err_unexp !== 1'b1) begin
      n_fail++; $display("FAIL rmid_err: got %b want 1", err_unexp);
    end
    step();
    step();
    @(negedge clk);
    n_tests++;
    if (err_unexp !== 1'b1) begin
      n_fail++; $display("FAIL rmid_sticky: got %b want 1", err_unexp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    test_reset();
    test_single_writer();
    test_contention();
    test_read_steering();
    test_full();
    test_waitrequest();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
